// File: rtl/leb128_fetch.sv
// LEB128 varint/varuint decoder that streams bytes from a synchronous ROM.
// Define LEB128_64B_EN to enable 64-bit operands; otherwise is_64 requests end with error 3.
module leb128_fetch #(
    parameter int MEM_DEPTH = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [MEM_DEPTH:0]           addr_in,
    input  logic                         is_signed,
    input  logic                         is_64,
    output logic                         busy,
    output logic                         done,
    output logic [63:0]                  value,
    output logic [3:0]                   length,
    output logic [1:0]                   error,
    output logic [MEM_DEPTH:0]           mem_addr,
    output logic [MEM_EXTRA-1:0]         mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]  mem_data,
    input  logic                         mem_error
);

    localparam int DW = (2**MEM_EXTRA) * 8;
    localparam logic [MEM_DEPTH:0] ADDR_ONE = (MEM_DEPTH+1)'(1);

`ifdef LEB128_64B_EN
    localparam bit HAS_64 = 1'b1;
`else
    localparam bit HAS_64 = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PRIME, DECODE} state_t;

    state_t      state;
    logic        sgn;
    logic        w64;
    logic [63:0] acc;
    logic [3:0]  cnt;
    logic [6:0]  sh;

    logic [7:0]  cur;
    logic [63:0] acc_nx;
    logic [6:0]  sh_nx;
    logic [63:0] ext;
    logic [63:0] res;
    logic        at_last;
    logic        ovf;
    logic        fin;

    logic unused_data;
    assign unused_data = ^{1'b0, mem_data[DW-1:8]};

    assign mem_extra = '0;

    always_comb begin
        cur     = mem_data[7:0];
        acc_nx  = acc | ({57'd0, cur[6:0]} << sh);
        sh_nx   = sh + 7'd7;
        at_last = (cnt == (w64 ? 4'd9 : 4'd4));
        ovf     = 1'b0;
        // Final byte: unused payload bits must be zero (unsigned) or copies of the sign.
        if (at_last) begin
            if (w64)
                ovf = sgn ? (cur[6:1] != {6{cur[0]}}) : (cur[6:1] != 6'd0);
            else
                ovf = sgn ? (cur[6:4] != {3{cur[3]}}) : (cur[6:4] != 3'd0);
            ovf = ovf | cur[7];
        end
        fin = mem_error | ovf | ~cur[7];
        ext = (sgn && cur[6]) ? (acc_nx | (~64'd0 << sh_nx)) : acc_nx;
        if (w64)
            res = ext;
        else if (sgn)
            res = {{32{ext[31]}}, ext[31:0]};
        else
            res = {32'd0, ext[31:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            value    <= '0;
            length   <= '0;
            error    <= '0;
            mem_addr <= '0;
            sgn      <= 1'b0;
            w64      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            sh       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        value  <= '0;
                        length <= '0;
                        error  <= '0;
                        if (is_64 && !HAS_64) begin
                            done  <= 1'b1;
                            error <= 2'd3;
                        end else begin
                            state    <= PRIME;
                            busy     <= 1'b1;
                            mem_addr <= addr_in;
                            sgn      <= is_signed;
                            w64      <= is_64;
                            acc      <= '0;
                            cnt      <= '0;
                            sh       <= '0;
                        end
                    end
                end
                PRIME: begin
                    state    <= DECODE;
                    mem_addr <= mem_addr + ADDR_ONE;
                end
                DECODE: begin
                    mem_addr <= mem_addr + ADDR_ONE;
                    acc      <= acc_nx;
                    cnt      <= cnt + 4'd1;
                    sh       <= sh_nx;
                    if (fin) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        length <= cnt + 4'd1;
                        if (mem_error) begin
                            error <= 2'd2;
                            value <= '0;
                        end else if (ovf) begin
                            error <= 2'd1;
                            value <= '0;
                        end else begin
                            error <= 2'd0;
                            value <= res;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: directed vectors plus random streams against a numeric model.
module tb_leb128_fetch;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [6:0]   addr_in;
    logic         is_signed;
    logic         is_64;
    logic         busy;
    logic         done;
    logic [63:0]  value;
    logic [3:0]   length;
    logic [1:0]   error;
    logic [6:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data;
    logic         mem_error;

    logic [7:0] rom [128];
    bit         err_map [128];

    int errors = 0;
    int checks = 0;

    leb128_fetch dut (
        .clk(clk), .reset(reset), .start(start), .addr_in(addr_in),
        .is_signed(is_signed), .is_64(is_64), .busy(busy), .done(done),
        .value(value), .length(length), .error(error), .mem_addr(mem_addr),
        .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= {{15{8'hA5}}, rom[mem_addr]};
        mem_error <= err_map[mem_addr];
    end

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) begin
            rom[i] = 8'(i * 37 + 5);
            err_map[i] = 1'b0;
        end
    endtask

    task automatic load(input logic [6:0] a, input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) rom[7'(a + 7'(i))] = b[i];
    endtask

    // Numeric reference: sum payloads, apply sign, then range-check the integer.
    function automatic void model(input logic [6:0] a, input bit sg, input bit w,
                                  output logic [63:0] v, output logic [3:0] l,
                                  output logic [1:0] e);
        logic signed [127:0] tot;
        logic signed [127:0] one;
        logic [7:0] b;
        int lim;
        int width;
        bit bad;
        one = 1;
        tot = 0;
        v = '0; l = '0; e = '0;
`ifndef LEB128_64B_EN
        if (w) begin
            e = 2'd3;
            return;
        end
`endif
        lim = w ? 10 : 5;
        width = w ? 64 : 32;
        for (int n = 1; n <= lim; n++) begin
            b = rom[7'(a + 7'(n - 1))];
            l = 4'(n);
            if (err_map[7'(a + 7'(n - 1))]) begin
                e = 2'd2;
                return;
            end
            tot = tot + ((one * b[6:0]) <<< (7 * (n - 1)));
            if (!b[7]) begin
                if (sg && b[6]) tot = tot - (one <<< (7 * n));
                if (sg)
                    bad = (tot < -(one <<< (width - 1))) || (tot >= (one <<< (width - 1)));
                else
                    bad = tot >= (one <<< width);
                if (bad) e = 2'd1;
                else v = tot[63:0];
                return;
            end
        end
        e = 2'd1;
    endfunction

    task automatic run(input logic [6:0] a, input bit sg, input bit w, input bit poke,
                       output logic [63:0] v, output logic [3:0] l,
                       output logic [1:0] e, output int lat);
        @(negedge clk);
        addr_in = a; is_signed = sg; is_64 = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (poke && lat == 1) begin
                start = 1'b1; addr_in = ~a; is_signed = ~sg;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = -1;
        v = value; l = length; e = error;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; addr_in = '0; is_signed = 0; is_64 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, value, length, error, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b v=%h l=%0d e=%0d a=%h, need all 0",
                     busy, done, value, length, error, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic vec(input string nm, input logic [6:0] a, input bit sg, input bit w,
                       input bit poke, input logic [63:0] xv, input logic [3:0] xl,
                       input logic [1:0] xe, input int xlat);
        logic [63:0] v; logic [3:0] l; logic [1:0] e; int lat;
        run(a, sg, w, poke, v, l, e, lat);
        checks++;
        if (v !== xv || l !== xl || e !== xe || lat != xlat) begin
            errors++;
            $display("FAIL %s: got v=%h l=%0d e=%0d lat=%0d, need v=%h l=%0d e=%0d lat=%0d",
                     nm, v, l, e, lat, xv, xl, xe, xlat);
        end
    endtask

    task automatic test_vectors();
        logic [6:0] a0;
        clear_mem();
        load(7'd54, '{8'h04});
        err_map[55] = 1'b1;
        vec("single_byte", 7'd54, 0, 0, 0, 64'd4, 4'd1, 2'd0, 2);
        load(7'd10, '{8'hE5, 8'h8E, 8'h26});
        vec("unsigned_3b", 7'd10, 0, 0, 1, 64'd624485, 4'd3, 2'd0, 4);
        load(7'd20, '{8'hC0, 8'hBB, 8'h78});
        vec("signed_3b", 7'd20, 1, 0, 0, 64'hFFFFFFFFFFFE1DC0, 4'd3, 2'd0, 4);
        load(7'd30, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00});
        vec("cont_at_5th", 7'd30, 0, 0, 0, 64'd0, 4'd5, 2'd1, 6);
        load(7'd40, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F});
        vec("u32_overflow", 7'd40, 0, 0, 0, 64'd0, 4'd5, 2'd1, 6);
        load(7'd60, '{8'hE5, 8'h8E, 8'h26});
        err_map[61] = 1'b1;
        vec("mem_fault", 7'd60, 0, 0, 0, 64'd0, 4'd2, 2'd2, 3);
        load(7'd80, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01});
        a0 = mem_addr;
`ifdef LEB128_64B_EN
        vec("u64_max", 7'd80, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF, 4'd10, 2'd0, 11);
`else
        vec("u64_unsupported", 7'd80, 0, 1, 0, 64'd0, 4'd0, 2'd3, 0);
        checks++;
        if (mem_addr !== a0) begin
            errors++;
            $display("FAIL u64_addr_kept: got %h, need %h", mem_addr, a0);
        end
`endif
    endtask

    task automatic test_hold();
        logic [63:0] v0;
        v0 = value;
        repeat (5) @(negedge clk);
        checks++;
        if (value !== v0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold: got v=%h done=%b busy=%b, need v=%h done=0 busy=0",
                     value, done, busy, v0);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_mem();
        load(7'd5, '{8'h81, 8'h82, 8'h83, 8'h04});
        load(7'h7F, '{8'h80, 8'h01});
        @(negedge clk);
        addr_in = 7'd5; is_signed = 0; is_64 = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b a=%h, need 0 0 00", busy, done, mem_addr);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_done: got %0d pulses, need 0", seen);
        end
        vec("wrap_7f", 7'h7F, 0, 0, 0, 64'd128, 4'd2, 2'd0, 3);
    endtask

    task automatic test_random();
        logic [63:0] v, xv; logic [3:0] l, xl; logic [1:0] e, xe;
        logic [6:0] a; int lat, n, xlat; bit sg, w; logic [7:0] b;
        for (int i = 0; i < 60; i++) begin
            clear_mem();
            a = 7'($urandom);
            sg = 1'($urandom);
            w = 1'($urandom);
            n = w ? $urandom_range(1, 11) : $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 3) == 0) b[6:0] = sg ? {7{b[0]}} : 7'd0;
                b[7] = (j < n - 1);
                rom[7'(a + 7'(j))] = b;
            end
            if ($urandom_range(0, 3) == 0)
                err_map[7'(a + 7'($urandom_range(0, n)))] = 1'b1;
            model(a, sg, w, xv, xl, xe);
            xlat = (xe == 2'd3) ? 0 : int'(xl) + 1;
            run(a, sg, w, 1'($urandom), v, l, e, lat);
            checks++;
            if (v !== xv || l !== xl || e !== xe || lat != xlat) begin
                errors++;
                $display("FAIL random_%0d: got v=%h l=%0d e=%0d lat=%0d, need v=%h l=%0d e=%0d lat=%0d",
                         i, v, l, e, lat, xv, xl, xe, xlat);
            end
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
